// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: word/mask aliases and arbiter FSM states.
// Latency: none (types only).
// Backpressure: none (types only).
package mem_port_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_A,
    SERVE_B,
    RESP_A,
    RESP_B
  } lc3b_arb_state;

  // Identity of the most recently granted port, used for round-robin.
  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } arb_port_e;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter for performance monitoring; clr wins over inc.
// Latency: count reflects inc/clr one cycle after they are sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk, reset (sync, active-high), inc, clr, count[WIDTH-1:0].
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (A: instruction, B: data) to one downstream memory port arbiter, round-robin on conflict.
// Latency: grant in IDLE cycle 0, mem op in cycle 1, resp_x one cycle after mem_resp (min 2 cycles).
// Backpressure: a port's request is held by its initiator until resp_x; the other port waits in IDLE.
//
// Ports: clk, reset (sync, active-high); port A/B request (read/write/wmask/address/wdata) and
// response (resp/rdata); downstream mem_read/mem_write/mem_wmask/mem_address/mem_wdata out,
// mem_resp/mem_rdata in; conflict_count_reset in, conflict_count out.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   read_a,
  input  logic                   write_a,
  input  lc3b_mem_wmask          wmask_a,
  input  lc3b_word               address_a,
  input  lc3b_word               wdata_a,
  output logic                   resp_a,
  output lc3b_word               rdata_a,

  input  logic                   read_b,
  input  logic                   write_b,
  input  lc3b_mem_wmask          wmask_b,
  input  lc3b_word               address_b,
  input  lc3b_word               wdata_b,
  output logic                   resp_b,
  output lc3b_word               rdata_b,

  output logic                   mem_read,
  output logic                   mem_write,
  output lc3b_mem_wmask          mem_wmask,
  output lc3b_word               mem_address,
  output lc3b_word               mem_wdata,
  input  logic                   mem_resp,
  input  lc3b_word               mem_rdata,

  input  logic                   conflict_count_reset,
  output logic [COUNT_WIDTH-1:0] conflict_count
);

  lc3b_arb_state state, state_next;
  arb_port_e     last_grant;

  // Latched request of the granted port; the downstream port is driven only from these.
  logic          req_read;
  logic          req_write;
  lc3b_mem_wmask req_wmask;
  lc3b_word      req_address;
  lc3b_word      req_wdata;

  logic pend_a, pend_b;
  logic grant_a, grant_b;
  logic capture_a, capture_b;
  logic conflict;
  logic serving;

  assign pend_a = read_a | write_a;
  assign pend_b = read_b | write_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    capture_a   = 1'b0;
    capture_b   = 1'b0;
    conflict    = 1'b0;
    serving     = 1'b0;
    resp_a      = 1'b0;
    resp_b      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wmask   = '0;
    mem_address = '0;
    mem_wdata   = '0;

    unique case (state)
      IDLE: begin
        if (pend_a && pend_b) begin
          conflict = 1'b1;
          if (last_grant == GRANT_B) grant_a = 1'b1;
          else                       grant_b = 1'b1;
        end else if (pend_a) begin
          grant_a = 1'b1;
        end else if (pend_b) begin
          grant_b = 1'b1;
        end
        if (grant_a)      state_next = SERVE_A;
        else if (grant_b) state_next = SERVE_B;
      end
      SERVE_A: begin
        serving = 1'b1;
        if (mem_resp) begin
          capture_a  = 1'b1;
          state_next = RESP_A;
        end
      end
      SERVE_B: begin
        serving = 1'b1;
        if (mem_resp) begin
          capture_b  = 1'b1;
          state_next = RESP_B;
        end
      end
      RESP_A: begin
        resp_a     = 1'b1;
        state_next = IDLE;
      end
      RESP_B: begin
        resp_b     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outside SERVE the downstream port is forced to zero so stale request
    // registers never leak out between transactions.
    if (serving) begin
      mem_read    = req_read;
      mem_write   = req_write;
      mem_wmask   = req_wmask;
      mem_address = req_address;
      mem_wdata   = req_wdata;
    end
  end

  // Request latch; a port asserting both read and write is treated as a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant  <= GRANT_B;
      req_read    <= 1'b0;
      req_write   <= 1'b0;
      req_wmask   <= '0;
      req_address <= '0;
      req_wdata   <= '0;
    end else if (grant_a) begin
      last_grant  <= GRANT_A;
      req_read    <= read_a & ~write_a;
      req_write   <= write_a;
      req_wmask   <= wmask_a;
      req_address <= address_a;
      req_wdata   <= wdata_a;
    end else if (grant_b) begin
      last_grant  <= GRANT_B;
      req_read    <= read_b & ~write_b;
      req_write   <= write_b;
      req_wmask   <= wmask_b;
      req_address <= address_b;
      req_wdata   <= wdata_b;
    end
  end

  // Read data is captured on every completion (writes too) and held until the
  // next completion for the same port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (capture_a) rdata_a <= mem_rdata;
      if (capture_b) rdata_b <= mem_rdata;
    end
  end

  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_conflict_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (conflict),
    .clr   (conflict_count_reset),
    .count (conflict_count)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with immediate-assertion checks.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: mem_resp is driven directly by the bench to model downstream wait states.
module tb_mem_port_arbiter;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          read_a, write_a, read_b, write_b;
  logic [1:0]    wmask_a, wmask_b;
  logic [15:0]   address_a, wdata_a, address_b, wdata_b;
  logic          resp_a, resp_b;
  logic [15:0]   rdata_a, rdata_b;
  logic          mem_read, mem_write;
  logic [1:0]    mem_wmask;
  logic [15:0]   mem_address, mem_wdata;
  logic          mem_resp;
  logic [15:0]   mem_rdata;
  logic          conflict_count_reset;
  logic [CW-1:0] conflict_count;

  int total;
  int bad;

  mem_port_arbiter #(.COUNT_WIDTH(CW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .read_a               (read_a),
    .write_a              (write_a),
    .wmask_a              (wmask_a),
    .address_a            (address_a),
    .wdata_a              (wdata_a),
    .resp_a               (resp_a),
    .rdata_a              (rdata_a),
    .read_b               (read_b),
    .write_b              (write_b),
    .wmask_b              (wmask_b),
    .address_b            (address_b),
    .wdata_b              (wdata_b),
    .resp_b               (resp_b),
    .rdata_b              (rdata_b),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .mem_wmask            (mem_wmask),
    .mem_address          (mem_address),
    .mem_wdata            (mem_wdata),
    .mem_resp             (mem_resp),
    .mem_rdata            (mem_rdata),
    .conflict_count_reset (conflict_count_reset),
    .conflict_count       (conflict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    read_a = 1'b0; write_a = 1'b0; wmask_a = 2'b00; address_a = '0; wdata_a = '0;
    read_b = 1'b0; write_b = 1'b0; wmask_b = 2'b00; address_b = '0; wdata_b = '0;
    mem_resp = 1'b0; mem_rdata = '0; conflict_count_reset = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Called in a SERVE cycle: checks the downstream read, completes it in the
  // same cycle, checks the one-cycle response, drops the request, ends in IDLE.
  task automatic serve_read(input bit is_a, input logic [15:0] exp_addr, input logic [15:0] rd);
    chk("serve_mem_read", 16'(mem_read), 16'h1);
    chk("serve_mem_address", mem_address, exp_addr);
    mem_resp  = 1'b1;
    mem_rdata = rd;
    tick();
    mem_resp  = 1'b0;
    chk("serve_resp_a", 16'(resp_a), 16'(is_a));
    chk("serve_resp_b", 16'(resp_b), 16'(!is_a));
    chk("serve_rdata", is_a ? rdata_a : rdata_b, rd);
    chk("serve_resp_mem_read", 16'(mem_read), 16'h0);
    if (is_a) read_a = 1'b0;
    else      read_b = 1'b0;
    tick();
  endtask

  // Both ports read from an IDLE cycle; a_first selects the expected order.
  task automatic do_pair(input bit a_first, input logic [15:0] exp_cnt);
    read_a = 1'b1; address_a = 16'h00A0;
    read_b = 1'b1; address_b = 16'h00B0;
    tick();
    chk("pair_count", 16'(conflict_count), exp_cnt);
    serve_read(a_first, a_first ? 16'h00A0 : 16'h00B0, 16'h1111);
    tick();
    serve_read(!a_first, a_first ? 16'h00B0 : 16'h00A0, 16'h2222);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    do_reset();

    // Reset state.
    chk("rst_mem_read", 16'(mem_read), 16'h0);
    chk("rst_mem_write", 16'(mem_write), 16'h0);
    chk("rst_mem_address", mem_address, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_mem_wmask", 16'(mem_wmask), 16'h0);
    chk("rst_resp_a", 16'(resp_a), 16'h0);
    chk("rst_resp_b", 16'(resp_b), 16'h0);
    chk("rst_rdata_a", rdata_a, 16'h0);
    chk("rst_rdata_b", rdata_b, 16'h0);
    chk("rst_count", 16'(conflict_count), 16'h0);

    // 1: port A read, response on the first SERVE cycle.
    read_a = 1'b1; address_a = 16'h1234;
    chk("t1_c0_mem_read", 16'(mem_read), 16'h0);
    tick();
    chk("t1_c1_resp_b", 16'(resp_b), 16'h0);
    chk("t1_c1_resp_a", 16'(resp_a), 16'h0);
    serve_read(1'b1, 16'h1234, 16'hBEEF);
    chk("t1_idle_resp_a", 16'(resp_a), 16'h0);
    chk("t1_hold_rdata_a", rdata_a, 16'hBEEF);
    chk("t1_idle_mem_read", 16'(mem_read), 16'h0);

    // 7: address_a changes during SERVE_A; the latched address is used.
    read_a = 1'b1; address_a = 16'h1234;
    tick();
    address_a = 16'h9999;
    tick();
    chk("t7_latched_addr", mem_address, 16'h1234);
    serve_read(1'b1, 16'h1234, 16'h0F0F);

    // 2: port B write with five wait cycles before mem_resp.
    write_b = 1'b1; address_b = 16'h0040; wdata_b = 16'hA5A5; wmask_b = 2'b01;
    tick();
    address_b = 16'h7777; wdata_b = 16'h0000; wmask_b = 2'b11;
    for (int i = 0; i < 5; i++) begin
      chk("t2_mem_write", 16'(mem_write), 16'h1);
      chk("t2_mem_read", 16'(mem_read), 16'h0);
      chk("t2_mem_address", mem_address, 16'h0040);
      chk("t2_mem_wdata", mem_wdata, 16'hA5A5);
      chk("t2_mem_wmask", 16'(mem_wmask), 16'h1);
      chk("t2_wait_resp_b", 16'(resp_b), 16'h0);
      tick();
    end
    chk("t2_last_mem_write", 16'(mem_write), 16'h1);
    mem_resp = 1'b1; mem_rdata = 16'h3C3C;
    tick();
    mem_resp = 1'b0;
    chk("t2_resp_b_hi", 16'(resp_b), 16'h1);
    chk("t2_resp_a_lo", 16'(resp_a), 16'h0);
    chk("t2_resp_mem_write", 16'(mem_write), 16'h0);
    write_b = 1'b0;
    tick();
    chk("t2_resp_b_lo", 16'(resp_b), 16'h0);
    chk("t2_rdata_a_kept", rdata_a, 16'h0F0F);

    // 3: both pending straight from reset -> A then B, one conflict.
    do_reset();
    do_pair(1'b1, 16'h1);
    chk("t3_count", 16'(conflict_count), 16'h1);

    // 4: last_grant=B -> A first; then single A so last_grant=A -> B first.
    tick();
    do_pair(1'b1, 16'h2);
    read_a = 1'b1; address_a = 16'h00A0;
    tick();
    serve_read(1'b1, 16'h00A0, 16'h5555);
    do_pair(1'b0, 16'h3);
    chk("t4_count", 16'(conflict_count), 16'h3);

    // 5: reset mid-SERVE_B, late mem_resp ignored.
    read_b = 1'b1; address_b = 16'h0040;
    tick();
    chk("t5_serve_b", 16'(mem_read), 16'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0; read_b = 1'b0;
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    chk("t5_mem_read", 16'(mem_read), 16'h0);
    chk("t5_mem_address", mem_address, 16'h0);
    chk("t5_resp_b", 16'(resp_b), 16'h0);
    chk("t5_count", 16'(conflict_count), 16'h0);
    tick();
    mem_resp = 1'b0;
    chk("t5_after_resp_b", 16'(resp_b), 16'h0);
    chk("t5_after_rdata_b", rdata_b, 16'h0);
    chk("t5_after_mem_write", 16'(mem_write), 16'h0);
    tick();
    chk("t5_late_resp_b", 16'(resp_b), 16'h0);

    // 6: saturation at all-ones (4-bit counter here), then clear beats increment.
    for (int i = 1; i <= 17; i++) begin
      do_pair(1'b1, (i > 15) ? 16'hF : 16'(i));
    end
    chk("t6_saturated", 16'(conflict_count), 16'hF);
    read_a = 1'b1; address_a = 16'h00A0;
    read_b = 1'b1; address_b = 16'h00B0;
    conflict_count_reset = 1'b1;
    tick();
    conflict_count_reset = 1'b0;
    chk("t6_clr_over_inc", 16'(conflict_count), 16'h0);
    serve_read(1'b1, 16'h00A0, 16'h1111);
    tick();
    serve_read(1'b0, 16'h00B0, 16'h2222);
    chk("t6_after_clr", 16'(conflict_count), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
